// File: rtl/urv_divide.sv
// uRV iterative RV32M divider: restoring division on magnitudes,
// one step per cycle, then a sign-fix cycle.
module urv_divide #(
  parameter bit g_fast_special = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  output logic        x_stall_req_o,
  input  logic [31:0] d_rs1_i,
  input  logic [31:0] d_rs2_i,
  input  logic [2:0]  d_fun_i,
  input  logic        d_is_divide_i,
  output logic [31:0] x_rd_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        is_rem_q, is_rem_d;
  logic [31:0] rd_q, rd_d;

  logic        is_signed;
  logic        is_rem_in;
  logic        accept;
  logic        div0;
  logic        ovf;
  logic        special;
  logic [31:0] special_res;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        no_borrow;
  logic [31:0] fix_res;

  always_comb begin
    is_signed = ~d_fun_i[0];
    is_rem_in = d_fun_i[1];
    accept    = (state_q == IDLE) && d_is_divide_i
              && d_fun_i[2] && !x_kill_i;
    div0      = (d_rs2_i == 32'h0);
    ovf       = is_signed && (d_rs1_i == 32'h8000_0000)
              && (d_rs2_i == 32'hffff_ffff);
    special   = g_fast_special && (div0 || ovf);
    if (div0)
      special_res = is_rem_in ? d_rs1_i : 32'hffff_ffff;
    else
      special_res = is_rem_in ? 32'h0 : 32'h8000_0000;
    rs1_mag = (is_signed && d_rs1_i[31]) ? -d_rs1_i : d_rs1_i;
    rs2_mag = (is_signed && d_rs2_i[31]) ? -d_rs2_i : d_rs2_i;
    // a set top bit means the shifted value dwarfs any 32-bit divisor
    shifted   = {rem_q[31:0], quo_q[31]};
    diff      = shifted - {1'b0, div_q};
    no_borrow = rem_q[32] || (shifted >= {1'b0, div_q});
    if (is_rem_q)
      fix_res = neg_r_q ? -rem_q[31:0] : rem_q[31:0];
    else
      fix_res = neg_q_q ? -quo_q : quo_q;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    is_rem_d = is_rem_q;
    rd_d     = rd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d    = 33'h0;
          quo_d    = rs1_mag;
          div_d    = rs2_mag;
          cnt_d    = 5'd31;
          // zero divisor keeps quotient all-ones for any dividend sign
          neg_q_d  = is_signed && !div0
                   && (d_rs1_i[31] != d_rs2_i[31]);
          neg_r_d  = is_signed && d_rs1_i[31];
          is_rem_d = is_rem_in;
          if (special) begin
            rd_d    = special_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (x_kill_i) begin
          state_d = IDLE;
        end else begin
          rem_d = no_borrow ? diff : shifted;
          quo_d = {quo_q[30:0], no_borrow};
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0)
            state_d = FIX;
        end
      end
      FIX: begin
        if (x_kill_i) begin
          state_d = IDLE;
        end else begin
          rd_d    = fix_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (x_kill_i || !x_stall_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      rem_q    <= 33'h0;
      quo_q    <= 32'h0;
      div_q    <= 32'h0;
      cnt_q    <= 5'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      rd_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      is_rem_q <= is_rem_d;
      rd_q     <= rd_d;
    end
  end

  assign x_stall_req_o = rst_n_i && !x_kill_i
                       && (accept || (state_q == CALC)
                           || (state_q == FIX));
  assign x_rd_o = rd_q;

endmodule

// File: tb/tb_urv_divide.sv
// Scoreboard bench for urv_divide: fast-special and full-iteration
// instances, checking results, stall lengths, kill, DONE hold, reset.
module tb_urv_divide;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_stall = 1'b0;
  logic        x_kill = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  fun = 3'b100;
  logic        is_div_f = 1'b0;
  logic        is_div_s = 1'b0;
  logic        stall_f, stall_s;
  logic [31:0] rd_f, rd_s;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  urv_divide u_dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .x_stall_i     (x_stall),
    .x_kill_i      (x_kill),
    .x_stall_req_o (stall_f),
    .d_rs1_i       (rs1),
    .d_rs2_i       (rs2),
    .d_fun_i       (fun),
    .d_is_divide_i (is_div_f),
    .x_rd_o        (rd_f)
  );

  urv_divide #(.g_fast_special(1'b0)) u_dut_slow (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .x_stall_i     (x_stall),
    .x_kill_i      (x_kill),
    .x_stall_req_o (stall_s),
    .d_rs1_i       (rs1),
    .d_rs2_i       (rs2),
    .d_fun_i       (fun),
    .d_is_divide_i (is_div_s),
    .x_rd_o        (rd_s)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic ov;
    ov = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (f)
      3'b100: ref_div = (b == 0) ? 32'hffff_ffff :
                        ov ? 32'h8000_0000 :
                        32'($signed(a) / $signed(b));
      3'b101: ref_div = (b == 0) ? 32'hffff_ffff : a / b;
      3'b110: ref_div = (b == 0) ? a : ov ? 32'h0 :
                        32'($signed(a) % $signed(b));
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue at a negedge, count stall cycles until DONE, then compare.
  task automatic run_op(input bit slow, input string tag,
                        input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_v, input int exp_st,
                        input bit hold);
    exp_t e;
    int n;
    logic st;
    logic [31:0] rd;
    e.tag = tag;
    e.val = exp_v;
    e.stalls = exp_st;
    sb.push_back(e);
    @(negedge clk);
    fun = f;
    rs1 = a;
    rs2 = b;
    is_div_f = !slow;
    is_div_s = slow;
    n = 0;
    forever begin
      #1;
      st = slow ? stall_s : stall_f;
      if (!st || n >= 80) break;
      n++;
      @(negedge clk);
    end
    rd = slow ? rd_s : rd_f;
    e = sb.pop_front();
    chk({e.tag, "_rd"}, rd, e.val);
    chk({e.tag, "_stalls"}, n, e.stalls);
    if (hold) begin
      x_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        chk("hold_stall", {31'b0, slow ? stall_s : stall_f}, 32'h0);
        chk("hold_rd", slow ? rd_s : rd_f, e.val);
      end
      x_stall = 1'b0;
    end
    is_div_f = 1'b0;
    is_div_s = 1'b0;
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb, ev;
    int          es;
    repeat (2) @(negedge clk);
    is_div_f = 1'b1;
    #1;
    chk("rst_stall", {31'b0, stall_f}, 32'h0);
    chk("rst_rd", rd_f, 32'h0);
    is_div_f = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, "divu", 3'b101, 100, 7, 32'd14, 34, 0);
    run_op(0, "remu", 3'b111, 100, 7, 32'd2, 34, 0);
    run_op(0, "div_n7_2", 3'b100, 32'hffff_fff9, 2,
           32'hffff_fffd, 34, 0);
    run_op(0, "rem_n7_2", 3'b110, 32'hffff_fff9, 2,
           32'hffff_ffff, 34, 0);
    run_op(0, "div_7_n2", 3'b100, 7, 32'hffff_fffe,
           32'hffff_fffd, 34, 0);
    run_op(0, "rem_7_n2", 3'b110, 7, 32'hffff_fffe, 32'd1, 34, 0);
    run_op(0, "div0", 3'b100, 32'h1234_5678, 0,
           32'hffff_ffff, 1, 0);
    run_op(0, "remu0", 3'b111, 32'h1234_5678, 0,
           32'h1234_5678, 1, 0);
    run_op(1, "div0_slow", 3'b100, 32'h1234_5678, 0,
           32'hffff_ffff, 34, 0);
    run_op(1, "remu0_slow", 3'b111, 32'h1234_5678, 0,
           32'h1234_5678, 34, 0);
    run_op(0, "ovf_div", 3'b100, 32'h8000_0000, 32'hffff_ffff,
           32'h8000_0000, 1, 0);
    run_op(0, "ovf_rem", 3'b110, 32'h8000_0000, 32'hffff_ffff,
           32'h0, 1, 0);
    run_op(0, "ovf_divu", 3'b101, 32'h8000_0000, 32'hffff_ffff,
           32'h0, 34, 0);
    run_op(1, "ovf_div_slow", 3'b100, 32'h8000_0000, 32'hffff_ffff,
           32'h8000_0000, 34, 0);

    // kill at CALC cycle 10; previous result must survive
    @(negedge clk);
    fun = 3'b101;
    rs1 = 100;
    rs2 = 7;
    is_div_f = 1'b1;
    repeat (10) @(negedge clk);
    x_kill = 1'b1;
    is_div_f = 1'b0;
    #1;
    chk("kill_stall", {31'b0, stall_f}, 32'h0);
    @(negedge clk);
    x_kill = 1'b0;
    #1;
    chk("kill_rd", rd_f, 32'h0);
    run_op(0, "after_kill", 3'b101, 9, 3, 32'd3, 34, 0);

    run_op(0, "done_hold", 3'b101, 1000, 10, 32'd100, 34, 1);
    run_op(0, "after_hold", 3'b111, 1000, 7, 32'd6, 34, 0);

    for (int i = 0; i < 8; i++) begin
      rf = 3'(4 + (i % 4));
      ra = $urandom;
      rb = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      ev = ref_div(rf, ra, rb);
      es = (rb == 0 || (!rf[0] && ra == 32'h8000_0000
                        && rb == 32'hffff_ffff)) ? 1 : 34;
      run_op(0, $sformatf("rand%0d", i), rf, ra, rb, ev, es, 0);
    end

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    fun = 3'b100;
    rs1 = 32'h7fff_0000;
    rs2 = 5;
    is_div_f = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", {31'b0, stall_f}, 32'h0);
    chk("arst_rd", rd_f, 32'h0);
    is_div_f = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, "after_rst", 3'b101, 9, 3, 32'd3, 34, 0);

    chk("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/urv_divide.md
# urv_divide

Iterative RV32M divider (DIV, DIVU, REM, REMU) for the uRV execute stage. It sits beside the multiply unit: it takes the same decode-stage operands and function code and stalls X through `x_stall_req_o` while it iterates. It then presents a registered 32-bit result to the X-stage destination mux. It uses one restoring-division step per cycle on operand magnitudes, then a single sign-fix cycle.

## Interface
- `g_fast_special`, default 1: when 1, divide-by-zero and signed overflow bypass iteration and finish in 2 cycles. When 0, they run the full iteration, which yields the same architectural results.
- `clk_i`  in  1  core clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `x_stall_i`  in  1  X stage frozen by another source.
- `x_kill_i`  in  1  instruction in X is being killed (branch/exception).
- `x_stall_req_o`  out  1  divider busy; hold X stage.
- `d_rs1_i`  in  32  dividend.
- `d_rs2_i`  in  32  divisor.
- `d_fun_i`  in  3  function code: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `d_is_divide_i`  in  1  current X instruction is a divide/remainder.
- `x_rd_o`  out  32  result (quotient or remainder), registered.

## Operation
- States are IDLE, CALC, FIX, DONE.
- **IDLE:**
  - Accept when `d_is_divide_i && !x_kill_i`.
  - On accept, latch `|rs1|` and `|rs2|` as magnitudes. Signed functions (DIV, REM) use two's-complement negation when bit 31 is set; unsigned functions use the raw values.
  - Also latch: `neg_q` = signed and sign(rs1) != sign(rs2); `neg_r` = signed and rs1[31]; and the `is_rem` flag.
  - Clear the 33-bit partial remainder, load the quotient register with the dividend magnitude, and load the 5-bit counter with 31.
- **Special cases** (`g_fast_special`=1, checked at accept, next state DONE):
  - rs2==0: quotient 0xFFFFFFFF; remainder = rs1 unmodified.
  - DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient 0x80000000; remainder 0.
- **CALC:** each cycle, perform one restoring step:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem[32:0].
  - If there is no borrow, keep the difference and set quo[0]=1; otherwise restore and set quo[0]=0.
  - Decrement the counter. After the step at count 0, go to FIX (32 steps total).
- **FIX:**
  - `x_rd_o` <= `is_rem` ? (`neg_r` ? -rem : rem) : (`neg_q` ? -quo : quo).
  - Go to DONE.
- **DONE:**
  - `x_rd_o` is held.
  - Go to IDLE when `!x_stall_i`; stay in DONE otherwise.
  - No new accept is possible from DONE, so the same instruction is never restarted.
- **`x_stall_req_o`** is combinational:
  - High in IDLE-and-accepting, CALC, and FIX.
  - Low in DONE and in plain IDLE.
  - Forced low whenever `x_kill_i` is high.
- **Kill:**
  - `x_kill_i` in CALC, FIX, or DONE sends the state to IDLE on the next edge.
  - `x_rd_o` is not updated.
- **Reset:**
  - Asynchronous assertion at any time forces IDLE, `x_rd_o`=0, counter=0, and all latched flags=0.
  - `x_stall_req_o` is 0 while in reset.
- **`x_stall_i`** in CALC/FIX does not pause iteration. The divider runs to completion regardless.

## Timing
- **Normal op:**
  - Cycle 0 = accept, with stall high.
  - Cycles 1–32 = CALC, with stall high.
  - Cycle 33 = FIX, with stall high; `x_rd_o` is updated at the end of this cycle.
  - Cycle 34 = DONE, with stall low and `x_rd_o` valid; the instruction leaves X at the end of cycle 34.
  - Result: 34 stall cycles, 35-cycle occupancy.
- **Special op:**
  - Cycle 0 = accept, with stall high; `x_rd_o` is written at the end of cycle 0.
  - Cycle 1 = DONE.
  - Result: 1 stall cycle.
- **Back-to-back divides:** the second divide is accepted in the IDLE cycle immediately after DONE exits, with no dead cycle beyond that.
- **Kill and stall in the same cycle:** kill wins.

## Test plan
- **DIVU:** rs1=100, rs2=7 -> `x_stall_req_o` high exactly 34 cycles; `x_rd_o`=14 in DONE. REMU with the same operands -> 2.
- **Signed DIV/REM:** DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIV 7/-2 -> 0xFFFFFFFD. REM 7/-2 -> 1.
- **Divide by zero:** DIV 0x12345678/0 -> 0xFFFFFFFF with a 1-cycle stall. REMU 0x12345678/0 -> 0x12345678. Repeat with `g_fast_special`=0 -> same values, 34-cycle stall.
- **Signed overflow:** DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. DIVU with the same operands -> 0x00000000.
- **Kill:** pulse `x_kill_i` at CALC cycle 10 -> stall low that cycle, IDLE next cycle, `x_rd_o` unchanged. Then present DIVU 9/3 -> 3 after the normal 34-cycle stall.
- **Stall in DONE, then reset:** hold `x_stall_i` high for 3 cycles in DONE -> state stays DONE, `x_rd_o` stable, no re-accept. Separately, assert `rst_n_i` low asynchronously mid-CALC -> stall and `x_rd_o` go to 0 immediately; after release the unit is IDLE.
